// File: rtl/fir_pkg.sv
// Shared definitions for the parameterised transposed-form FIR filter.
//   - default parameter values used by fir_pipe_param and fir_coef_bank
//   - coef_word_t: coefficient word at the default coefficient width
//   - sat_clip(): clips a wide signed value to a signed out_w-bit range
package fir_pkg;

    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_COEF_W     = 32;
    localparam int unsigned DEF_NUM_TAPS   = 102;
    localparam int unsigned DEF_ACC_W      = 64;
    localparam int unsigned DEF_OUT_W      = 32;
    localparam int unsigned DEF_FRAC_SHIFT = 31;

    // Working width of the saturation helper; ACC_W must not exceed it.
    localparam int unsigned SAT_W = 128;

    typedef logic signed [DEF_COEF_W-1:0] coef_word_t;

    typedef struct packed {
        logic                    sat;
        logic signed [SAT_W-1:0] val;
    } sat_res_t;

    // Clip v to [-2^(out_w-1), 2^(out_w-1)-1]; the caller keeps the low out_w bits of val.
    function automatic sat_res_t sat_clip(input logic signed [SAT_W-1:0] v,
                                          input int unsigned             out_w);
        sat_res_t                res;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = '0;
        for (int i = 0; i < SAT_W; i++) begin
            hi[i] = (32'(i) + 32'd1 < out_w);
        end
        lo      = ~hi;  // two's complement: ~(2^(n-1)-1) == -2^(n-1)
        res.sat = 1'b0;
        res.val = v;
        if (v > hi) begin
            res.sat = 1'b1;
            res.val = hi;
        end else if (v < lo) begin
            res.sat = 1'b1;
            res.val = lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient storage for the FIR filter.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset (clears both banks, bank 0 active)
//   i_we         : write strobe; i_data goes into the shadow bank at i_addr
//   i_addr       : tap index; indices >= NUM_TAPS are ignored
//   i_data       : coefficient value
//   i_swap       : one-cycle pulse exchanging active and shadow banks
//   o_coef       : active-bank coefficient vector feeding the multipliers
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int unsigned COEF_W   = DEF_COEF_W,
    parameter int unsigned NUM_TAPS = DEF_NUM_TAPS
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_we,
    input  logic [7:0]               i_addr,
    input  logic signed [COEF_W-1:0] i_data,
    input  logic                     i_swap,
    output logic signed [COEF_W-1:0] o_coef [NUM_TAPS]
);

    localparam int unsigned AW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

    logic signed [COEF_W-1:0] r_bank0 [NUM_TAPS];
    logic signed [COEF_W-1:0] r_bank1 [NUM_TAPS];
    logic                     r_sel;  // 0: bank0 active, 1: bank1 active
    logic                     w_addr_ok;
    logic [AW-1:0]            w_idx;

    assign w_addr_ok = (32'(i_addr) < NUM_TAPS);
    assign w_idx     = i_addr[AW-1:0];

    // Writes always target the bank that is shadow before this edge, so a write
    // coincident with a swap lands in the bank that becomes active.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sel <= 1'b0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                r_bank0[k] <= '0;
                r_bank1[k] <= '0;
            end
        end else begin
            if (i_swap) begin
                r_sel <= ~r_sel;
            end
            if (i_we && w_addr_ok) begin
                if (r_sel) begin
                    r_bank0[w_idx] <= i_data;
                end else begin
                    r_bank1[w_idx] <= i_data;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            o_coef[k] = r_sel ? r_bank1[k] : r_bank0[k];
        end
    end

endmodule

// File: rtl/fir_pipe_param.sv
// Parameterised transposed-form FIR filter with double-buffered coefficients.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : d_in carries a sample this cycle (stalls hold all state)
//   d_in       : signed input sample
//   coef_we    : shadow-bank coefficient write strobe, with coef_addr / coef_data
//   coef_swap  : exchanges active and shadow banks
//   out_valid  : d_out valid this cycle (one cycle after in_valid)
//   d_out      : (y >>> FRAC_SHIFT) saturated to OUT_W bits
//   out_sat    : d_out was clipped
// ACC_W must be >= DATA_W+COEF_W+clog2(NUM_TAPS) and <= SAT_W.
module fir_pipe_param
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned COEF_W     = DEF_COEF_W,
    parameter int unsigned NUM_TAPS   = DEF_NUM_TAPS,
    parameter int unsigned ACC_W      = DEF_ACC_W,
    parameter int unsigned OUT_W      = DEF_OUT_W,
    parameter int unsigned FRAC_SHIFT = DEF_FRAC_SHIFT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] d_in,
    input  logic                     coef_we,
    input  logic [7:0]               coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    input  logic                     coef_swap,
    output logic                     out_valid,
    output logic signed [OUT_W-1:0]  d_out,
    output logic                     out_sat
);

    localparam int unsigned MUL_W = DATA_W + COEF_W;

    logic signed [COEF_W-1:0] w_coef [NUM_TAPS];
    logic signed [MUL_W-1:0]  w_mul  [NUM_TAPS];
    logic signed [ACC_W-1:0]  w_prod [NUM_TAPS];
    logic signed [ACC_W-1:0]  r_z    [NUM_TAPS-1];
    logic signed [ACC_W-1:0]  w_y;
    logic signed [ACC_W-1:0]  w_y_shift;
    sat_res_t                 w_sat;

    logic                     r_out_valid;
    logic signed [OUT_W-1:0]  r_d_out;
    logic                     r_out_sat;

    fir_coef_bank #(
        .COEF_W   (COEF_W),
        .NUM_TAPS (NUM_TAPS)
    ) u_coef_bank (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_we   (coef_we),
        .i_addr (coef_addr),
        .i_data (coef_data),
        .i_swap (coef_swap),
        .o_coef (w_coef)
    );

    // Products use the bank active before this edge, so a sample accepted with
    // coef_swap is still computed with the old coefficients.
    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            w_mul[k]  = MUL_W'(w_coef[k]) * MUL_W'(d_in);
            w_prod[k] = ACC_W'(w_mul[k]);
        end
    end

    assign w_y       = w_prod[0] + r_z[0];
    assign w_y_shift = w_y >>> FRAC_SHIFT;
    assign w_sat     = sat_clip(SAT_W'(w_y_shift), OUT_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_TAPS - 1; k++) begin
                r_z[k] <= '0;
            end
            r_out_valid <= 1'b0;
            r_d_out     <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                for (int k = 0; k < NUM_TAPS - 2; k++) begin
                    r_z[k] <= r_z[k+1] + w_prod[k+1];
                end
                r_z[NUM_TAPS-2] <= w_prod[NUM_TAPS-1];
                r_d_out         <= OUT_W'(w_sat.val);
                r_out_sat       <= w_sat.sat;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign d_out     = r_d_out;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_fir_pipe_param.sv
// Directed bench for fir_pipe_param. Two instances share all inputs:
// dut_a uses FRAC_SHIFT=0, dut_b uses FRAC_SHIFT=31 (ramp test only).
module tb_fir_pipe_param;
    import fir_pkg::*;

    localparam int NT = 102;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic signed [15:0] d_in;
    logic              coef_we;
    logic [7:0]        coef_addr;
    coef_word_t        coef_data;
    logic              coef_swap;

    logic              out_valid_a, out_sat_a;
    logic signed [31:0] d_out_a;
    logic              out_valid_b, out_sat_b;
    logic signed [31:0] d_out_b;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    fir_pipe_param #(
        .FRAC_SHIFT (0)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .d_in      (d_in),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .coef_swap (coef_swap),
        .out_valid (out_valid_a),
        .d_out     (d_out_a),
        .out_sat   (out_sat_a)
    );

    fir_pipe_param #(
        .FRAC_SHIFT (31)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .d_in      (d_in),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .coef_swap (coef_swap),
        .out_valid (out_valid_b),
        .d_out     (d_out_b),
        .out_sat   (out_sat_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input logic [7:0] a, input coef_word_t d);
        coef_we   = 1'b1;
        coef_addr = a;
        coef_data = d;
        tick();
        coef_we   = 1'b0;
    endtask

    task automatic swap_banks();
        coef_swap = 1'b1;
        tick();
        coef_swap = 1'b0;
    endtask

    task automatic sample(input logic signed [15:0] x);
        in_valid = 1'b1;
        d_in     = x;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic signed [31:0] held;
        rst       = 1'b1;
        in_valid  = 1'b0;
        d_in      = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        coef_swap = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_d_out", d_out_a, 0);
        chk("rst_out_sat", out_sat_a, 0);
        rst = 1'b0;

        // Coefficients only in the shadow bank: response must stay zero
        for (int k = 0; k < NT; k++) write_coef(8'(k), coef_word_t'(k + 1));
        sample(16'sd1);
        chk("preswap_valid", out_valid_a, 1);
        chk("preswap_y0", d_out_a, 0);
        sample(16'sd0);
        chk("preswap_y1", d_out_a, 0);
        swap_banks();
        chk("swap_no_valid", out_valid_a, 0);

        // Impulse response, back-to-back samples: 1..102 then 0
        for (int i = 0; i <= NT; i++) begin
            sample((i == 0) ? 16'sd1 : 16'sd0);
            chk($sformatf("imp_valid[%0d]", i), out_valid_a, 1);
            chk($sformatf("imp_y[%0d]", i), d_out_a, (i < NT) ? i + 1 : 0);
        end

        // Same impulse with in_valid on alternate cycles
        for (int i = 0; i <= NT; i++) begin
            sample((i == 0) ? 16'sd1 : 16'sd0);
            chk($sformatf("alt_valid[%0d]", i), out_valid_a, 1);
            chk($sformatf("alt_y[%0d]", i), d_out_a, (i < NT) ? i + 1 : 0);
            held = d_out_a;
            tick();
            chk($sformatf("alt_stall_valid[%0d]", i), out_valid_a, 0);
            chk($sformatf("alt_stall_hold[%0d]", i), d_out_a, (i < NT) ? i + 1 : 0);
            chk($sformatf("alt_stall_same[%0d]", i), d_out_a, held);
        end

        // Step response with h[k]=2^30, FRAC_SHIFT=31: 50,100,...,5100 then hold
        do_reset();
        for (int k = 0; k < NT; k++) write_coef(8'(k), 32'sh4000_0000);
        swap_banks();
        for (int n = 1; n <= NT + 8; n++) begin
            sample(16'sd100);
            chk($sformatf("step_y[%0d]", n), d_out_b, ((n < NT) ? n : NT) * 50);
            chk($sformatf("step_sat[%0d]", n), out_sat_b, 0);
        end

        // Saturation at both rails, and the largest value that is not clipped
        do_reset();
        write_coef(8'd0, 32'sh7FFF_FFFF);
        swap_banks();
        sample(16'sd32767);
        chk("sat_hi_y", d_out_a, 64'sd2147483647);
        chk("sat_hi_flag", out_sat_a, 1);
        sample(-16'sd32768);
        chk("sat_lo_y", d_out_a, -64'sd2147483648);
        chk("sat_lo_flag", out_sat_a, 1);
        sample(16'sd1);
        chk("nosat_y", d_out_a, 64'sd2147483647);
        chk("nosat_flag", out_sat_a, 0);

        // Bank swap coincident with a sample and with a coefficient write
        write_coef(8'd0, 32'sh8000_0001);
        write_coef(8'd200, 32'sd7);  // out of range, must be dropped
        coef_swap = 1'b1;
        coef_we   = 1'b1;
        coef_addr = 8'd1;
        coef_data = 32'sd5;
        sample(16'sd1);
        coef_swap = 1'b0;
        coef_we   = 1'b0;
        chk("swap_old_bank_y", d_out_a, 64'sd2147483647);
        sample(16'sd1);
        chk("swap_new_bank_y", d_out_a, -64'sd2147483647);
        chk("swap_new_bank_sat", out_sat_a, 0);
        sample(16'sd0);
        chk("swap_we_lands_active", d_out_a, 5);
        sample(16'sd0);
        chk("swap_tail_zero", d_out_a, 0);

        // Asynchronous reset in the middle of an impulse response
        sample(16'sd1);
        chk("prerst_y", d_out_a, -64'sd2147483647);
        rst      = 1'b1;
        in_valid = 1'b1;
        d_in     = 16'sd0;
        #1;
        chk("async_rst_valid", out_valid_a, 0);
        chk("async_rst_d_out", d_out_a, 0);
        chk("async_rst_sat", out_sat_a, 0);
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("postrst_no_valid", out_valid_a, 0);
        sample(16'sd1);
        chk("postrst_valid", out_valid_a, 1);
        chk("postrst_y0", d_out_a, 0);
        sample(16'sd0);
        chk("postrst_y1", d_out_a, 0);
        swap_banks();
        sample(16'sd1);
        chk("postrst_swap_y0", d_out_a, 0);
        sample(16'sd0);
        chk("postrst_swap_y1", d_out_a, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
